// File: rtl/rfphoenix_alu128_sched_pkg.sv
// rfPhoenixPkg: shared types for the quad-precision issue path.
//   instruction_t : opcode/function pair decoded by the 128-bit ALU
//   quad_value_t  : 128-bit operand/result value
//   s1_rec_t      : operand-stage record (ir, a, b, c, id, tag) of the scheduler
// The id/tag fields of s1_rec_t are sized for the largest configuration
// (8 requesters, 16-bit tags); narrower instances zero-extend into them.
package rfPhoenixPkg;

    localparam int DEF_NREQ = 4;
    localparam int DEF_TAGW = 6;
    localparam int MAX_IDW  = 3;
    localparam int MAX_TAGW = 16;

    // Major opcodes
    localparam logic [5:0] OP_R2      = 6'h02;
    localparam logic [5:0] OP_R3      = 6'h03;
    // Function codes
    localparam logic [5:0] OP_ADD     = 6'h04;
    localparam logic [5:0] OP_SUB     = 6'h05;
    localparam logic [5:0] OP_AND     = 6'h08;
    localparam logic [5:0] OP_OR      = 6'h09;
    localparam logic [5:0] OP_XOR     = 6'h0A;
    localparam logic [5:0] OP_CMP_LT  = 6'h10;
    localparam logic [5:0] OP_CMP_LTU = 6'h11;
    localparam logic [5:0] OP_MUX     = 6'h20;

    typedef logic [127:0] quad_value_t;

    typedef struct packed {
        logic [5:0] func;
        logic [5:0] opcode;
    } instruction_t;

    typedef struct packed {
        instruction_t          ir;
        quad_value_t           a;
        quad_value_t           b;
        quad_value_t           c;
        logic [MAX_IDW-1:0]    id;
        logic [MAX_TAGW-1:0]   tag;
    } s1_rec_t;

endpackage

// File: rtl/rfphoenix_alu128.sv
// rfphoenix_alu128: combinational 128-bit scalar/quad ALU.
// Ports:
//   ir      in  instruction (opcode + function)
//   a, b, c in  128-bit operands (c is the select mask for OP_MUX)
//   o       out 128-bit result; undecoded opcodes/functions give 0
module rfphoenix_alu128
    import rfPhoenixPkg::*;
(
    input  instruction_t ir,
    input  quad_value_t  a,
    input  quad_value_t  b,
    input  quad_value_t  c,
    output quad_value_t  o
);

    always_comb begin
        o = '0;
        case (ir.opcode)
            OP_R2: begin
                case (ir.func)
                    OP_ADD:     o = a + b;
                    OP_SUB:     o = a - b;
                    OP_AND:     o = a & b;
                    OP_OR:      o = a | b;
                    OP_XOR:     o = a ^ b;
                    OP_CMP_LT:  o = {127'd0, ($signed(a) < $signed(b))};
                    OP_CMP_LTU: o = {127'd0, (a < b)};
                    default:    o = '0;
                endcase
            end
            OP_R3: begin
                case (ir.func)
                    OP_MUX:  o = (a & c) | (b & ~c);
                    default: o = '0;
                endcase
            end
            default: o = '0;
        endcase
    end

endmodule

// File: rtl/rfphoenix_alu128_sched_rr_arb.sv
// rfphoenix_rr_arb: combinational round-robin arbiter.
// Ports:
//   req   in  N        request vector
//   ptr   in  log2(N)  index of the last winner; search starts at ptr+1
//   en    in  1        arbitration enable; grant is zero when low
//   grant out N        one-hot grant (or zero)
//   idx   out log2(N)  encoded index of the winner (0 when no grant)
module rfphoenix_rr_arb #(
    parameter int N = 4
) (
    input  logic [N-1:0]          req,
    input  logic [$clog2(N)-1:0]  ptr,
    input  logic                  en,
    output logic [N-1:0]          grant,
    output logic [$clog2(N)-1:0]  idx
);

    localparam int IW = $clog2(N);

    // One extra bit so ptr+k (k up to N) never overflows before the wrap.
    logic [IW:0] cand;
    logic        found;

    always_comb begin
        grant = '0;
        idx   = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            cand = {1'b0, ptr} + (IW+1)'(k);
            if (cand >= (IW+1)'(N)) begin
                cand = cand - (IW+1)'(N);
            end
            if (en && !found && req[cand[IW-1:0]]) begin
                found                = 1'b1;
                grant[cand[IW-1:0]]  = 1'b1;
                idx                  = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/rfphoenix_alu128_sched.sv
// rfphoenix_alu128_sched: round-robin scheduler sharing one 128-bit ALU
// among NREQ issue requesters. Two stages: S1 holds the winning operands,
// S2 holds the ALU result behind a valid/ready handshake.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous pipeline flush (drops S1 and S2)
//   req_valid/req_ready   per-requester handshake; req_ready is one-hot
//   req_ir/a/b/c/tag      per-requester instruction, operands, tag
//   res_valid/res_ready   result handshake
//   res_o/res_id/res_tag  result, winning requester index, its tag
//   busy                  S1 or S2 occupied
module rfphoenix_alu128_sched
    import rfPhoenixPkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int TAGW = DEF_TAGW
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  instruction_t             req_ir  [NREQ],
    input  quad_value_t              req_a   [NREQ],
    input  quad_value_t              req_b   [NREQ],
    input  quad_value_t              req_c   [NREQ],
    input  logic [TAGW-1:0]          req_tag [NREQ],
    output logic                     res_valid,
    input  logic                     res_ready,
    output quad_value_t              res_o,
    output logic [$clog2(NREQ)-1:0]  res_id,
    output logic [TAGW-1:0]          res_tag,
    output logic                     busy
);

    localparam int IDW = $clog2(NREQ);

    s1_rec_t           s1_reg;
    logic              s1_v_reg;
    quad_value_t       s2_o_reg;
    logic [IDW-1:0]    s2_id_reg;
    logic [TAGW-1:0]   s2_tag_reg;
    logic              s2_v_reg;
    logic [IDW-1:0]    ptr_reg;

    s1_rec_t           cand_rec [NREQ];
    s1_rec_t           s1_next;
    logic [NREQ-1:0]   grant;
    logic [IDW-1:0]    grant_idx;
    logic              xfer;
    logic              s2_adv;
    logic              s1_free;
    logic              arb_en;
    quad_value_t       alu_o;
    logic              unused_pad;

    // Per-requester candidate records for the operand stage.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
            assign cand_rec[gi] = '{
                ir:  req_ir[gi],
                a:   req_a[gi],
                b:   req_b[gi],
                c:   req_c[gi],
                id:  MAX_IDW'(gi),
                tag: MAX_TAGW'(req_tag[gi])
            };
        end
    endgenerate

    assign s2_adv  = s1_v_reg & (~s2_v_reg | res_ready);
    assign s1_free = ~s1_v_reg | s2_adv;
    // rst_n is folded in so req_ready drops immediately on an async reset.
    assign arb_en  = s1_free & ~flush & rst_n;

    rfphoenix_rr_arb #(
        .N (NREQ)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr_reg),
        .en    (arb_en),
        .grant (grant),
        .idx   (grant_idx)
    );

    assign xfer      = |grant;
    assign req_ready = grant;
    assign s1_next   = cand_rec[grant_idx];

    rfphoenix_alu128 u_alu (
        .ir (s1_reg.ir),
        .a  (s1_reg.a),
        .b  (s1_reg.b),
        .c  (s1_reg.c),
        .o  (alu_o)
    );

    // The record carries id/tag at their widest; the padding above IDW/TAGW
    // is always zero and is not needed downstream.
    assign unused_pad = ^{s1_reg.id >> IDW, s1_reg.tag >> TAGW};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_reg     <= '0;
            s1_v_reg   <= 1'b0;
            s2_o_reg   <= '0;
            s2_id_reg  <= '0;
            s2_tag_reg <= '0;
            s2_v_reg   <= 1'b0;
            ptr_reg    <= IDW'(NREQ - 1);
        end else if (flush) begin
            // A result handed over in this same cycle is still consumed
            // downstream; everything else in flight is dropped.
            s1_v_reg <= 1'b0;
            s2_v_reg <= 1'b0;
        end else begin
            if (xfer) begin
                s1_reg   <= s1_next;
                s1_v_reg <= 1'b1;
                ptr_reg  <= grant_idx;
            end else if (s2_adv) begin
                s1_v_reg <= 1'b0;
            end

            if (s2_adv) begin
                s2_o_reg   <= alu_o;
                s2_id_reg  <= s1_reg.id[IDW-1:0];
                s2_tag_reg <= s1_reg.tag[TAGW-1:0];
                s2_v_reg   <= 1'b1;
            end else if (res_ready) begin
                s2_v_reg <= 1'b0;
            end
        end
    end

    assign res_valid = s2_v_reg;
    assign res_o     = s2_o_reg;
    assign res_id    = s2_id_reg;
    assign res_tag   = s2_tag_reg;
    assign busy      = s1_v_reg | s2_v_reg;

endmodule

// File: tb/tb_rfphoenix_alu128_sched.sv
// Self-checking bench for rfphoenix_alu128_sched (NREQ=4, TAGW=6).
// Table-driven single-request vectors with hand-computed results, plus
// hand-written sequences for fairness, backpressure, flush and async reset.
// A scoreboard queue holds expected results pushed at each transfer.
module tb_rfphoenix_alu128_sched;
    import rfPhoenixPkg::*;

    localparam int N = 4;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    instruction_t      req_ir  [N];
    quad_value_t       req_a   [N];
    quad_value_t       req_b   [N];
    quad_value_t       req_c   [N];
    logic [5:0]        req_tag [N];
    logic              res_valid;
    logic              res_ready;
    quad_value_t       res_o;
    logic [1:0]        res_id;
    logic [5:0]        res_tag;
    logic              busy;

    rfphoenix_alu128_sched #(.NREQ(N), .TAGW(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_ir    (req_ir),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_c     (req_c),
        .req_tag   (req_tag),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_o     (res_o),
        .res_id    (res_id),
        .res_tag   (res_tag),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] o;
        logic [1:0]   id;
        logic [5:0]   tag;
    } exp_t;

    typedef struct {
        int           rq;
        logic [5:0]   op;
        logic [5:0]   fn;
        logic [127:0] a;
        logic [127:0] b;
        logic [127:0] c;
        logic [5:0]   tag;
        logic [127:0] exp;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[12];

    int n_checks  = 0;
    int n_fail    = 0;
    int n_results = 0;
    int model_ptr = N - 1;
    int last_grant;
    logic m_s1 = 1'b0;
    logic m_s2 = 1'b0;

    task automatic check(string nm, logic [127:0] act, logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] model_alu(logic [5:0] op, logic [5:0] fn,
                                               logic [127:0] a, logic [127:0] b,
                                               logic [127:0] c);
        if (op == OP_R2) begin
            if (fn == OP_ADD) return a + b;
            if (fn == OP_SUB) return a - b;
            if (fn == OP_AND) return a & b;
            if (fn == OP_OR)  return a | b;
            if (fn == OP_XOR) return a ^ b;
            if (fn == OP_CMP_LTU) return {127'd0, a < b};
            if (fn == OP_CMP_LT) begin
                if (a[127] != b[127]) return {127'd0, a[127]};
                return {127'd0, a < b};
            end
        end else if (op == OP_R3 && fn == OP_MUX) begin
            return (a & c) | (b & ~c);
        end
        return '0;
    endfunction

    task automatic set_req(int i, logic [5:0] op, logic [5:0] fn, logic [127:0] a,
                           logic [127:0] b, logic [127:0] c, logic [5:0] tag);
        req_ir[i]    = '{func: fn, opcode: op};
        req_a[i]     = a;
        req_b[i]     = b;
        req_c[i]     = c;
        req_tag[i]   = tag;
        req_valid[i] = 1'b1;
    endtask

    // Called at a falling edge with inputs already set; checks this cycle's
    // handshakes against the bench model, then advances to the next falling edge.
    task automatic cycle();
        logic [N-1:0] g;
        logic         s2_adv;
        exp_t         e;
        #1;
        s2_adv = m_s1 && (!m_s2 || res_ready);
        g = '0;
        if (!flush && (!m_s1 || s2_adv)) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (model_ptr + k) % N;
                if (g == '0 && req_valid[c]) g[c] = 1'b1;
            end
        end
        check("req_ready", 128'(req_ready), 128'(g));
        check("res_valid", 128'(res_valid), 128'(m_s2));
        check("busy", 128'(busy), 128'(m_s1 | m_s2));
        if (m_s2 && res_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got id=%0d o=0x%0h, expected none", res_id, res_o);
            end else begin
                e = sb.pop_front();
                n_results++;
                $display("txn result id=%0d tag=0x%0h o=0x%0h", res_id, res_tag, res_o);
                check("sb_o", res_o, e.o);
                check("sb_id", 128'(res_id), 128'(e.id));
                check("sb_tag", 128'(res_tag), 128'(e.tag));
            end
        end
        if (flush) sb.delete();
        last_grant = -1;
        for (int c = 0; c < N; c++) begin
            if (g[c]) begin
                sb.push_back('{model_alu(req_ir[c].opcode, req_ir[c].func, req_a[c],
                                         req_b[c], req_c[c]), 2'(c), req_tag[c]});
                model_ptr  = c;
                last_grant = c;
            end
        end
        if (flush) begin
            m_s1 = 1'b0;
            m_s2 = 1'b0;
        end else begin
            m_s2 = s2_adv ? 1'b1 : (res_ready ? 1'b0 : m_s2);
            m_s1 = (g != '0) ? 1'b1 : (s2_adv ? 1'b0 : m_s1);
        end
        @(negedge clk);
    endtask

    task automatic drain(int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int  k;
        int  base;
        bit  got;
        bit  got1;
        bit  got2;

        vecs[0]  = '{2,  OP_R2, OP_ADD,     128'd5,     128'd7, 128'd0,      6'h11, 128'd12};
        vecs[1]  = '{1,  OP_R2, OP_SUB,     128'd10,    128'd3, 128'd0,      6'h12, 128'd7};
        vecs[2]  = '{0,  OP_R2, OP_SUB,     128'd0,     128'd1, 128'd0,      6'h13, {128{1'b1}}};
        vecs[3]  = '{3,  OP_R2, OP_CMP_LTU, 128'd1,     {128{1'b1}}, 128'd0, 6'h14, 128'd1};
        vecs[4]  = '{2,  OP_R2, OP_CMP_LT,  128'd1,     {128{1'b1}}, 128'd0, 6'h15, 128'd0};
        vecs[5]  = '{0,  OP_R2, OP_AND,     128'hf0,    128'h3c, 128'd0,     6'h16, 128'h30};
        vecs[6]  = '{1,  OP_R2, OP_OR,      128'hf0,    128'h3c, 128'd0,     6'h17, 128'hfc};
        vecs[7]  = '{2,  OP_R2, OP_XOR,     128'hf0,    128'h3c, 128'd0,     6'h18, 128'hcc};
        vecs[8]  = '{3,  OP_R3, OP_MUX,     128'hffff,  128'h0,  128'h00ff,  6'h19, 128'h00ff};
        vecs[9]  = '{0,  6'h3F, OP_ADD,     128'd5,     128'd7,  128'd0,     6'h1A, 128'd0};
        vecs[10] = '{1,  OP_R2, OP_ADD,     128'hFFFF_FFFF_FFFF_FFFF, 128'd1, 128'd0, 6'h1B,
                     128'h1_0000_0000_0000_0000};
        vecs[11] = '{3,  OP_R2, OP_CMP_LT,  {128{1'b1}}, 128'd1, 128'd0,     6'h1C, 128'd1};

        rst_n     = 1'b0;
        flush     = 1'b0;
        res_ready = 1'b1;
        req_valid = '0;
        for (int i = 0; i < N; i++) begin
            req_ir[i]  = '0;
            req_a[i]   = '0;
            req_b[i]   = '0;
            req_c[i]   = '0;
            req_tag[i] = '0;
        end

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_res_valid", 128'(res_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_res_o", res_o, 128'd0);
        check("rst_res_id", 128'(res_id), 128'd0);
        check("rst_res_tag", 128'(res_tag), 128'd0);
        check("rst_req_ready", 128'(req_ready), 128'd0);
        rst_n = 1'b1;

        // Fairness: all requesters valid, one grant per cycle in rotation
        for (int i = 0; i < N; i++)
            set_req(i, OP_R2, OP_ADD, 128'(1000 * (i + 1)), 128'(i), 128'd0, 6'(i));
        for (int t = 0; t < 8; t++) begin
            cycle();
            check("fair_grant", 128'(last_grant), 128'(t % N));
        end
        req_valid = '0;
        drain(3);

        // Table vectors: one request at a time, two-cycle latency
        foreach (vecs[v]) begin
            set_req(vecs[v].rq, vecs[v].op, vecs[v].fn, vecs[v].a, vecs[v].b,
                    vecs[v].c, vecs[v].tag);
            got = 1'b0;
            for (int w = 0; w < 8 && !got; w++) begin
                cycle();
                if (last_grant == vecs[v].rq) got = 1'b1;
            end
            req_valid = '0;
            check("vec_granted", 128'(got), 128'd1);
            check("vec_lat_s1", 128'(res_valid), 128'd0);
            cycle();
            check("vec_lat_s2", 128'(res_valid), 128'd1);
            check("vec_o", res_o, vecs[v].exp);
            check("vec_id", 128'(res_id), 128'(vecs[v].rq));
            check("vec_tag", 128'(res_tag), 128'(vecs[v].tag));
            cycle();
        end

        // Backpressure: three SUBs from requester 1 with res_ready low
        base      = n_results;
        res_ready = 1'b0;
        k         = 0;
        set_req(1, OP_R2, OP_SUB, 128'd100, 128'd0, 128'd0, 6'h20);
        for (int t = 0; t < 5; t++) begin
            cycle();
            if (last_grant == 1) begin
                k++;
                if (k < 3) set_req(1, OP_R2, OP_SUB, 128'(100 + 10 * k), 128'(k), 128'd0, 6'(32 + k));
                else req_valid[1] = 1'b0;
            end
            if (res_valid) begin
                check("stall_o", res_o, 128'd100);
                check("stall_tag", 128'(res_tag), 128'h20);
            end
        end
        check("stall_accepted", 128'(k), 128'd2);
        res_ready = 1'b1;
        for (int w = 0; w < 20 && (k < 3 || sb.size() != 0 || m_s1 || m_s2); w++) begin
            cycle();
            if (last_grant == 1) begin
                k++;
                if (k < 3) set_req(1, OP_R2, OP_SUB, 128'(100 + 10 * k), 128'(k), 128'd0, 6'(32 + k));
                else req_valid[1] = 1'b0;
            end
        end
        check("bp_delivered", 128'(n_results - base), 128'd3);

        // Flush with S1 and S2 full and res_ready high in the same cycle
        res_ready = 1'b0;
        set_req(1, OP_R2, OP_SUB, 128'd50, 128'd8, 128'd0, 6'h31);
        set_req(2, OP_R2, OP_XOR, 128'd6, 128'd3, 128'd0, 6'h32);
        got1 = 1'b0;
        got2 = 1'b0;
        for (int w = 0; w < 6 && !(got1 && got2); w++) begin
            cycle();
            if (last_grant == 1) begin got1 = 1'b1; req_valid[1] = 1'b0; end
            if (last_grant == 2) begin got2 = 1'b1; req_valid[2] = 1'b0; end
        end
        check("flush_fill", 128'({got1, got2}), 128'b11);
        flush     = 1'b1;
        res_ready = 1'b1;
        cycle();
        flush = 1'b0;
        check("flush_res_valid", 128'(res_valid), 128'd0);
        check("flush_busy", 128'(busy), 128'd0);
        set_req(1, OP_R2, OP_ADD, 128'd1, 128'd1, 128'd0, 6'h33);
        set_req(3, OP_R2, OP_ADD, 128'd2, 128'd2, 128'd0, 6'h34);
        cycle();
        check("flush_next_grant", 128'(last_grant), 128'd3);
        req_valid[3] = 1'b0;
        cycle();
        req_valid[1] = 1'b0;
        drain(3);

        // Async reset mid-stream
        set_req(0, OP_R2, OP_ADD, 128'd9, 128'd9, 128'd0, 6'h3A);
        cycle();
        check("pre_rst_grant", 128'(last_grant), 128'd0);
        req_valid[0] = 1'b0;
        cycle();
        set_req(0, OP_R2, OP_ADD, 128'd4, 128'd4, 128'd0, 6'h3B);
        set_req(2, OP_R2, OP_ADD, 128'd3, 128'd3, 128'd0, 6'h3C);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_res_valid", 128'(res_valid), 128'd0);
        check("arst_busy", 128'(busy), 128'd0);
        check("arst_req_ready", 128'(req_ready), 128'd0);
        check("arst_res_o", res_o, 128'd0);
        m_s1      = 1'b0;
        m_s2      = 1'b0;
        model_ptr = N - 1;
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        check("post_rst_grant", 128'(last_grant), 128'd0);
        req_valid[0] = 1'b0;
        cycle();
        req_valid[2] = 1'b0;
        req_valid    = '0;
        drain(4);

        check("final_sb_empty", 128'(sb.size()), 128'd0);
        check("final_busy", 128'(busy), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
